// File: rtl/sha256_msg_schedule.sv
// Purpose: SHA-256 message schedule. Loads 16 words and emits W[0..63] from a 16-word shift window.
// Latency: out_valid rises the cycle after the 16th input handshake; then one word per output handshake with no bubbles.
// Backpressure: in_ready is low for the whole emit phase; out_ready low holds word, index and window unchanged.
//
// Ports:
//   clock, reset (async, active-low), flush (sync abort back to load)
//   in_valid/in_ready/in_word       : 16 big-endian message words, W[0] first
//   out_valid/out_ready/out_word    : schedule word W[out_index]
//   out_index (t), out_last (t==63), busy (first accepted word .. final output handshake)
module sha256_msg_schedule #(
    parameter int ROUNDS      = 64,
    parameter int BLOCK_WORDS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_index,
    output logic        out_last,
    output logic        busy
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam int T_W   = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [T_W-1:0]   T_LAST    = T_W'(ROUNDS - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_load_cnt;
    logic [T_W-1:0]   r_t;
    logic [31:0]      r_win [BLOCK_WORDS];
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_in_hs;
    logic             w_out_hs;
    logic [31:0]      w_nxt;

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_in_hs  = in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & out_ready;

    // Window holds W[t..t+15]; this is W[t+16] in the window's own coordinates.
    assign w_nxt = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LOAD;
            r_load_cnt  <= '0;
            r_t         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_win[i] <= '0;
            end
        end else if (flush) begin
            // Abort wins over any handshake this cycle; window contents are left as-is.
            r_state     <= S_LOAD;
            r_load_cnt  <= '0;
            r_t         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_hs) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[BLOCK_WORDS-1] <= in_word;
                        r_busy               <= 1'b1;
                        r_load_cnt           <= r_load_cnt + 1'b1;
                        if (r_load_cnt == LOAD_LAST) begin
                            r_state     <= S_EMIT;
                            r_load_cnt  <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_hs) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[BLOCK_WORDS-1] <= w_nxt;
                        r_t                  <= r_t + 1'b1;
                        if (r_t == T_LAST) begin
                            // Window is not cleared; the next load overwrites it.
                            r_state     <= S_LOAD;
                            r_t         <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = r_win[0];
    assign out_index = r_t;
    assign out_last  = r_out_valid & (r_t == T_LAST);
    assign busy      = r_busy;

endmodule
